// File: rtl/wishbone_arbiter2.sv
// wishbone_arbiter2: two-requester round-robin Wishbone arbiter that holds a grant for a whole bus cycle.
// Define WB_ARB_TIMEOUT_EN to compile in the ack watchdog (counter, TOUT state, timeout_err).
module wishbone_arbiter2 #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cyc_0,
    input  logic cyc_1,
    input  logic stb_0,
    input  logic stb_1,
    input  logic ack,
    output logic slave_select,
    output logic gnt_0,
    output logic gnt_1,
    output logic busy,
    output logic timeout_err
);

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2, TOUT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
`endif

    state_t state_q, state_d;
    logic   sel_q, sel_d;
    logic   last_q, last_d;
    logic   abort;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;
    logic             waiting;

    // The owner has a strobe outstanding and the slave has not answered this cycle.
    assign waiting = (((state_q == OWN0) && stb_0) || ((state_q == OWN1) && stb_1)) && !ack;
    assign abort   = waiting && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = '0;
        if (waiting && (state_d == state_q)) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= abort;
        end
    end

    assign timeout_err = err_q;
`else
    logic unused_inputs;

    assign abort         = 1'b0;
    assign timeout_err   = 1'b0;
    assign unused_inputs = ^{stb_0, stb_1, ack, TIMEOUT_CYCLES == 0, CNT_W == 0};
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                // On a tie the requester that did not own the bus last wins.
                if (cyc_0 && (!cyc_1 || last_q)) begin
                    state_d = OWN0;
                end else if (cyc_1) begin
                    state_d = OWN1;
                end
            end
            OWN0: if (!cyc_0) state_d = cyc_1 ? OWN1 : IDLE;
            OWN1: if (!cyc_1) state_d = cyc_0 ? OWN0 : IDLE;
`ifdef WB_ARB_TIMEOUT_EN
            TOUT: if (!(last_q ? cyc_1 : cyc_0)) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

`ifdef WB_ARB_TIMEOUT_EN
        if (abort) begin
            state_d = TOUT;
            last_d  = (state_q == OWN1);
        end
`endif

        if (state_d == OWN0) begin
            sel_d  = 1'b0;
            last_d = 1'b0;
        end else if (state_d == OWN1) begin
            sel_d  = 1'b1;
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign gnt_0        = (state_q == OWN0);
    assign gnt_1        = (state_q == OWN1);
    assign busy         = gnt_0 | gnt_1;
    assign slave_select = sel_q;

endmodule

// File: tb/tb_wishbone_arbiter2.sv
// Self-checking bench for wishbone_arbiter2: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a bus-ownership model.
module tb_wishbone_arbiter2;
    localparam int T = 8;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cyc_0 = 1'b0, cyc_1 = 1'b0, stb_0 = 1'b0, stb_1 = 1'b0, ack = 1'b0;
    logic slave_select, gnt_0, gnt_1, busy, timeout_err;
    logic [4:0] o;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    wishbone_arbiter2 #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .cyc_0(cyc_0), .cyc_1(cyc_1), .stb_0(stb_0), .stb_1(stb_1), .ack(ack),
        .slave_select(slave_select), .gnt_0(gnt_0), .gnt_1(gnt_1),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Output vector order: {gnt_0, gnt_1, busy, slave_select, timeout_err}
    assign o = {gnt_0, gnt_1, busy, slave_select, timeout_err};

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got {g0,g1,busy,sel,err}=%b want %b", name, $time, act, exp);
        end
    endtask

    // Ownership model: who owns the bus, round-robin pointer, abort recovery, stb wait length.
    int m_owner;
    int m_wait;
    bit m_last, m_sel, m_tout, m_err;
    bit mc[2];
    bit ms[2];

    task automatic model_grant(input int y);
        m_owner = y;
        m_last  = (y == 1);
        m_sel   = (y == 1);
        m_wait  = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_last = 1'b1; m_sel = 1'b0; m_tout = 1'b0; m_err = 1'b0; m_wait = 0;
        end else begin
            mc[0] = cyc_0; mc[1] = cyc_1; ms[0] = stb_0; ms[1] = stb_1;
            m_err = 1'b0;
            if (m_tout) begin
                if (!mc[m_last]) m_tout = 1'b0;
            end else if (m_owner >= 0) begin
                if (TO_EN && ms[m_owner] && !ack && m_wait == T - 1) begin
                    m_err = 1'b1; m_tout = 1'b1; m_last = (m_owner == 1); m_owner = -1; m_wait = 0;
                end else if (mc[m_owner]) begin
                    m_wait = (ms[m_owner] && !ack) ? m_wait + 1 : 0;
                end else if (mc[1 - m_owner]) begin
                    model_grant(1 - m_owner);
                end else begin
                    m_owner = -1; m_wait = 0;
                end
            end else if (mc[0] && mc[1]) begin
                model_grant(m_last ? 0 : 1);
            end else if (mc[0]) begin
                model_grant(0);
            end else if (mc[1]) begin
                model_grant(1);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n)
            check("model", o, {m_owner == 0, m_owner == 1, m_owner >= 0, m_sel, m_err});
    end

    task automatic drv(input bit c0, input bit s0, input bit c1, input bit s1, input bit a);
        cyc_0 = c0; stb_0 = s0; cyc_1 = c1; stb_1 = s1; ack = a;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        repeat (3) tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("reset", o, 5'b00000);

        // Simultaneous requests: 0 first, handover to 1, back to 0.
        drv(1, 0, 1, 0, 0); tick(); check("tie_first", o, 5'b10100);
        tick(); tick();
        drv(0, 0, 1, 0, 0); tick(); check("handover_1", o, 5'b01110);
        drv(1, 0, 1, 0, 0); tick(); tick();
        drv(1, 0, 0, 0, 0); tick(); check("handover_0", o, 5'b10100);
        drv(0, 0, 0, 0, 0); tick(); check("release", o, 5'b00000);

        // Owner 1 keeps the bus for 20 cycles despite requester 0 waiting.
        drv(0, 0, 1, 0, 0); tick(); check("own1", o, 5'b01110);
        drv(1, 0, 1, 0, 0);
        for (int i = 0; i < 19; i++) begin
            tick(); check("no_preempt", o, 5'b01110);
        end
        drv(1, 0, 0, 0, 0); tick(); check("after_hold", o, 5'b10100);
        drv(0, 0, 0, 0, 0); tick(); check("idle_sel0", o, 5'b00000);

        // Requester 0 strobes and never gets ack, requester 1 waiting.
        drv(1, 1, 0, 0, 0); tick(); check("wd_grant", o, 5'b10100);
        drv(1, 1, 1, 0, 0);
`ifdef WB_ARB_TIMEOUT_EN
        for (int i = 0; i < T - 1; i++) begin
            tick(); check("wd_wait", o, 5'b10100);
        end
        tick(); check("wd_abort", o, 5'b00001);
        tick(); check("wd_tout_hold", o, 5'b00000);
        drv(0, 0, 1, 0, 0); tick(); check("wd_tout_exit", o, 5'b00000);
        tick(); check("wd_then_1", o, 5'b01110);
`else
        for (int i = 0; i < 2 * T; i++) begin
            tick(); check("no_wd_hold", o, 5'b10100);
        end
        drv(0, 0, 1, 0, 0); tick(); check("no_wd_then_1", o, 5'b01110);
`endif
        drv(0, 0, 0, 0, 0); tick(); check("idle_sel1", o, 5'b00010);

        // ack in the limit cycle prevents the abort and restarts the wait count.
        drv(1, 1, 0, 0, 0); tick(); check("ack_grant", o, 5'b10100);
        for (int i = 0; i < T - 1; i++) begin
            tick(); check("ack_wait", o, 5'b10100);
        end
        drv(1, 1, 0, 0, 1); tick(); check("ack_wins", o, 5'b10100);
        drv(1, 1, 0, 0, 0);
        for (int i = 0; i < T - 1; i++) begin
            tick(); check("cnt_cleared", o, 5'b10100);
        end
        drv(0, 0, 0, 0, 0); tick(); check("ack_release", o, 5'b00000);

        // Asynchronous reset while requester 1 owns the bus.
        drv(0, 0, 1, 0, 0); tick(); check("pre_rst", o, 5'b01110);
        #2 rst_n = 1'b0;
        #1 check("async_rst", o, 5'b00000);
        tick();
        rst_n = 1'b1;
        drv(1, 0, 1, 0, 0); tick(); check("tie_after_rst", o, 5'b10100);
        drv(0, 0, 0, 0, 0); tick(); check("rst_release", o, 5'b00000);

        // Randomized traffic; alternating windows of rare and frequent ack.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) cyc_0 = ~cyc_0;
            if ($urandom_range(0, 5) == 0) cyc_1 = ~cyc_1;
            stb_0 = cyc_0 && ($urandom_range(0, 3) != 0);
            stb_1 = cyc_1 && ($urandom_range(0, 3) != 0);
            if (((i / 300) % 2) == 1) ack = ($urandom_range(0, 19) == 0);
            else                      ack = ($urandom_range(0, 2) == 0);
            tick();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
